signal_decay_sweeper: RTL and testbench
=======================================

Name: signal_decay_sweeper

Overview:
- Evaporates pheromone: on every game tick, walks every grid cell of the environment signal memory and rewrites each signal as cur minus DECAY_STEP, saturating at 0.
- Sits beside env_cache, directly downstream of the environment read port and upstream of its write port.
- Shares the single write port with the ant-update path and always yields it to ant writes.

Parameters:
- X_bits, 8, grid X coordinate width.
- Y_bits, 7, grid Y coordinate width.
- X_MAX, 159, last column (640/4 - 1).
- Y_MAX, 119, last row (480/4 - 1).
- SIGNAL_bits, 4, signal value width.
- DECAY_STEP, 1, amount subtracted per sweep.

Ports:
- newLocClock  in  1  system clock (50 MHz).
- RESET_SIM  in  1  synchronous, active-high reset.
- RUN  in  1  high once setup is finished; low forces IDLE.
- game_tick  in  1  one-cycle pulse that requests one sweep.
- ant_write_busy  in  1  ant path owns the write port this cycle (write_flag).
- ant_wr_x  in  X_bits  ant-path write column.
- ant_wr_y  in  Y_bits  ant-path write row.
- rd_x  out  X_bits  lookup column.
- rd_y  out  Y_bits  lookup row.
- rd_signal  in  SIGNAL_bits  signal at the registered address; valid 1 cycle after rd_x/rd_y.
- wr_x  out  X_bits  write column.
- wr_y  out  Y_bits  write row.
- wr_signal  out  SIGNAL_bits  decayed value.
- wr_en  out  1  write strobe.
- busy  out  1  a sweep is in progress.
- sweep_done  out  1  one-cycle pulse after the last cell.
- overrun  out  1  sticky: a game_tick arrived while busy.

Behaviour:
- Reset, all synchronous on newLocClock:
  - state=IDLE; cursor (cx,cy)=(0,0); all outputs 0; overrun cleared.
  - Reset during a sweep abandons it immediately; wr_en is 0 in the following cycle.
- RUN=0 behaves as reset, except overrun is held.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - game_tick and RUN -> READ, busy=1, cursor=(0,0).
- READ:
  - rd_x/rd_y = cursor, registered -> WAIT.
- WAIT:
  - Capture rd_signal into cur.
  - new = (cur > DECAY_STEP) ? cur - DECAY_STEP : 0, computed at SIGNAL_bits width with no wrap.
  - -> WRITE.
- WRITE:
  - If ant_write_busy=1: wr_en=0, stay in WRITE (stall), and hold the cursor and captured value.
  - Else if cur==0: no write (write suppressed); advance cursor.
  - Else: wr_en=1 with wr_x/wr_y=cursor and wr_signal=new for exactly one cycle; advance cursor.
  - Ant-collision rule: if ant_write_busy=1 was seen on any cycle between READ and the write, with (ant_wr_x,ant_wr_y)==cursor, the cell is skipped (no write). The ant's freshly written value wins. Track this with a per-cell dirty bit that is cleared on READ.
- Cursor advance:
  - cx increments.
  - cx==X_MAX wraps cx to 0 and increments cy.
  - cx==X_MAX and cy==Y_MAX -> DONE; otherwise -> READ.
- DONE:
  - sweep_done=1 for one cycle, busy=0 -> IDLE.
- Throughput: 3 cycles per cell without stalls, so 3*160*120 = 57600 cycles per sweep.
- game_tick while busy (including DONE) is ignored and sets overrun=1.
- A game_tick in the same cycle that the FSM is in IDLE starts a sweep; a tick arriving in the DONE cycle does not.
- wr_en is never asserted in the same cycle as ant_write_busy.

Decomposition:
- Shared package params.sv already holds X_bits, Y_bits, SIGNAL_bits.
- Add to params.sv:
  - GRID_X_MAX, GRID_Y_MAX, SIGNAL_DECAY_STEP.
  - typedef enum decay_state_t {IDLE, READ, WAIT, WRITE, DONE}.
- One natural sub-module: grid_cursor (X/Y raster counter with clear, advance and last-cell flag). It is reusable by env_cache and the sugar placer.

Test Plan:
- Reset → idle: assert RESET_SIM for 2 cycles with RUN=1 → all outputs 0, busy=0; then a game_tick pulse → busy=1 next cycle, and the first rd_x/rd_y = (0,0).
- Full sweep, no contention: memory model preloaded with signal 5 at (3,2), 1 at (159,119), 0 elsewhere.
  - After the tick: (3,2) is written with 4 and (159,119) with 0; no other writes.
  - sweep_done pulses exactly 57600±2 cycles after the tick; busy drops with it.
- Saturation: cell value 0 → no wr_en for that cell. Set DECAY_STEP=3 with cell value 2 → 0 is written, never 15.
- Stall: hold ant_write_busy=1 for 10 cycles while in WRITE at (7,0), with the ant at (50,50) → wr_en stays 0 for those 10 cycles. The write to (7,0) occurs on the first cycle after the busy drops, and the sweep then completes 10 cycles late.
- Ant collision: ant writes (20,4) while the sweeper is in WAIT at (20,4) → no sweeper write to (20,4); the memory holds the ant's value.
- Overrun / reset mid-sweep:
  - A second game_tick at cycle 1000 of a sweep → overrun=1 and the sweep is not restarted.
  - RESET_SIM at cycle 2000 → busy=0 and wr_en=0 the next cycle, and overrun clears.

Source files
------------

// File: rtl/signal_decay_sweeper_pkg.sv
// Shared constants and types for the environment signal path.
//   X_bits / Y_bits      : grid coordinate widths
//   SIGNAL_bits          : width of one stored pheromone value
//   GRID_X_MAX/Y_MAX     : last column / last row of the 160x120 grid
//   SIGNAL_DECAY_STEP    : amount one sweep removes from every cell
//   decay_state_t        : states of the decay sweeper FSM
package signal_decay_sweeper_pkg;

  localparam int X_bits            = 8;
  localparam int Y_bits            = 7;
  localparam int SIGNAL_bits       = 4;
  localparam int GRID_X_MAX        = 159;
  localparam int GRID_Y_MAX        = 119;
  localparam int SIGNAL_DECAY_STEP = 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } decay_state_t;

endpackage

// File: rtl/signal_decay_sweeper_grid_cursor.sv
// Raster-order X/Y cursor over the environment grid.
// Steps column first, wrapping to the next row after X_MAX, and wrapping
// back to (0,0) after the last cell. Usable by any grid walker.
//   clk      : clock
//   reset    : synchronous clear to (0,0)
//   clear    : synchronous clear to (0,0) (start of a new walk)
//   advance  : step to the next cell
//   cx, cy   : current cell
//   last     : current cell is (X_MAX, Y_MAX)
module signal_decay_sweeper_grid_cursor
  import signal_decay_sweeper_pkg::*;
#(
  parameter int X_bits = 8,
  parameter int Y_bits = 7,
  parameter int X_MAX  = 159,
  parameter int Y_MAX  = 119
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  output logic [X_bits-1:0] cx,
  output logic [Y_bits-1:0] cy,
  output logic              last
);

  localparam logic [X_bits-1:0] X_LAST = X_bits'(X_MAX);
  localparam logic [Y_bits-1:0] Y_LAST = Y_bits'(Y_MAX);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cx <= '0;
      cy <= '0;
    end else if (advance) begin
      if (cx == X_LAST) begin
        cx <= '0;
        cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  assign last = (cx == X_LAST) && (cy == Y_LAST);

endmodule

// File: rtl/signal_decay_sweeper.sv
// Pheromone evaporation sweeper. On each game tick it walks every grid cell,
// reads the stored signal, and writes back the signal reduced by DECAY_STEP
// (saturating at 0). It shares the environment write port with the ant
// update path and always yields to it.
//   newLocClock    : system clock
//   RESET_SIM      : synchronous active-high reset
//   RUN            : low holds the sweeper idle (overrun is kept)
//   game_tick      : one-cycle sweep request
//   ant_write_busy : ant path owns the write port this cycle
//   ant_wr_x/y     : cell the ant path is writing
//   rd_x/rd_y      : lookup address; rd_signal returns one cycle later
//   wr_x/wr_y      : write address, wr_signal decayed value, wr_en strobe
//   busy           : sweep in progress
//   sweep_done     : one-cycle pulse after the last cell
//   overrun        : sticky, a tick arrived while a sweep was still running
module signal_decay_sweeper #(
  parameter int X_bits      = signal_decay_sweeper_pkg::X_bits,
  parameter int Y_bits      = signal_decay_sweeper_pkg::Y_bits,
  parameter int X_MAX       = signal_decay_sweeper_pkg::GRID_X_MAX,
  parameter int Y_MAX       = signal_decay_sweeper_pkg::GRID_Y_MAX,
  parameter int SIGNAL_bits = signal_decay_sweeper_pkg::SIGNAL_bits,
  parameter int DECAY_STEP  = signal_decay_sweeper_pkg::SIGNAL_DECAY_STEP
) (
  input  logic                   newLocClock,
  input  logic                   RESET_SIM,
  input  logic                   RUN,
  input  logic                   game_tick,
  input  logic                   ant_write_busy,
  input  logic [X_bits-1:0]      ant_wr_x,
  input  logic [Y_bits-1:0]      ant_wr_y,
  output logic [X_bits-1:0]      rd_x,
  output logic [Y_bits-1:0]      rd_y,
  input  logic [SIGNAL_bits-1:0] rd_signal,
  output logic [X_bits-1:0]      wr_x,
  output logic [Y_bits-1:0]      wr_y,
  output logic [SIGNAL_bits-1:0] wr_signal,
  output logic                   wr_en,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   overrun
);

  import signal_decay_sweeper_pkg::*;

  localparam logic [SIGNAL_bits-1:0] STEP = SIGNAL_bits'(DECAY_STEP);

  decay_state_t           state;
  decay_state_t           state_next;
  logic [X_bits-1:0]      cx;
  logic [Y_bits-1:0]      cy;
  logic                   last_cell;
  logic                   cursor_clear;
  logic                   cursor_advance;
  logic [SIGNAL_bits-1:0] cur;
  logic [SIGNAL_bits-1:0] decayed;
  logic                   dirty;
  logic                   ant_hit;
  logic                   overrun_set;
  logic                   write_now;
  logic                   halt;

  // RUN low acts like reset for everything except the sticky overrun flag.
  assign halt = RESET_SIM || !RUN;

  signal_decay_sweeper_grid_cursor #(
    .X_bits (X_bits),
    .Y_bits (Y_bits),
    .X_MAX  (X_MAX),
    .Y_MAX  (Y_MAX)
  ) u_grid_cursor (
    .clk     (newLocClock),
    .reset   (halt),
    .clear   (cursor_clear),
    .advance (cursor_advance),
    .cx      (cx),
    .cy      (cy),
    .last    (last_cell)
  );

  // An ant write to the cell currently being processed means the ant's fresh
  // value must survive; the sweeper's copy is stale from then on.
  assign ant_hit = ant_write_busy && (ant_wr_x == cx) && (ant_wr_y == cy) &&
                   ((state == READ) || (state == WAIT) || (state == WRITE));

  // The lookup address is simply the cursor, which is stable from READ to WRITE.
  assign rd_x = cx;
  assign rd_y = cy;

  assign wr_en     = write_now;
  assign wr_x      = write_now ? cx : '0;
  assign wr_y      = write_now ? cy : '0;
  assign wr_signal = write_now ? decayed : '0;

  always_comb begin
    state_next     = state;
    cursor_clear   = 1'b0;
    cursor_advance = 1'b0;
    busy           = 1'b0;
    sweep_done     = 1'b0;
    write_now      = 1'b0;
    overrun_set    = game_tick && (state != IDLE);
    case (state)
      IDLE: begin
        if (game_tick && RUN) begin
          state_next   = READ;
          cursor_clear = 1'b1;
        end
      end
      READ: begin
        busy       = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        busy       = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        busy = 1'b1;
        // Yielding the port to the ant path is a stall: cursor and data hold.
        if (!ant_write_busy) begin
          write_now      = (cur != '0) && !dirty;
          cursor_advance = 1'b1;
          state_next     = last_cell ? DONE : READ;
        end
      end
      DONE: begin
        sweep_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge newLocClock) begin
    if (halt) begin
      state   <= IDLE;
      cur     <= '0;
      decayed <= '0;
      dirty   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == WAIT) begin
        cur     <= rd_signal;
        decayed <= (rd_signal > STEP) ? rd_signal - STEP : '0;
      end
      // Each cell starts clean when it enters READ.
      if (state_next == READ) begin
        dirty <= 1'b0;
      end else if (ant_hit) begin
        dirty <= 1'b1;
      end
    end
  end

  always_ff @(posedge newLocClock) begin
    if (RESET_SIM) begin
      overrun <= 1'b0;
    end else if (RUN && overrun_set) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_signal_decay_sweeper.sv
// Self-checking bench for signal_decay_sweeper.
// A full-size instance runs one complete randomized sweep with a stall and an
// ant collision, then overrun / RUN / mid-sweep reset scenarios. A small-grid
// instance with a decay step of 3 exercises saturation and a tick in DONE.
// Both environment memories live in the bench; expected contents come from
// the decay rule applied to the preloaded values.
module tb_signal_decay_sweeper;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int check_count;
  int error_count;

  // full-size instance
  logic       reset_sim, run, game_tick, ant_write_busy;
  logic [7:0] ant_wr_x, rd_x, wr_x;
  logic [6:0] ant_wr_y, rd_y, wr_y;
  logic [3:0] rd_signal, wr_signal, ant_val;
  logic       wr_en, busy, sweep_done, overrun;

  // small instance: 8x4 grid, decay step 3
  logic       s_reset, s_run, s_tick, s_ant_busy;
  logic [2:0] s_ant_x, s_rd_x, s_wr_x;
  logic [1:0] s_ant_y, s_rd_y, s_wr_y;
  logic [3:0] s_rd_signal, s_wr_signal;
  logic       s_wr_en, s_busy, s_done, s_overrun;

  signal_decay_sweeper dut (
    .newLocClock(clk), .RESET_SIM(reset_sim), .RUN(run), .game_tick(game_tick),
    .ant_write_busy(ant_write_busy), .ant_wr_x(ant_wr_x), .ant_wr_y(ant_wr_y),
    .rd_x(rd_x), .rd_y(rd_y), .rd_signal(rd_signal),
    .wr_x(wr_x), .wr_y(wr_y), .wr_signal(wr_signal), .wr_en(wr_en),
    .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
  );

  signal_decay_sweeper #(
    .X_bits(3), .Y_bits(2), .X_MAX(7), .Y_MAX(3), .SIGNAL_bits(4), .DECAY_STEP(3)
  ) dut_small (
    .newLocClock(clk), .RESET_SIM(s_reset), .RUN(s_run), .game_tick(s_tick),
    .ant_write_busy(s_ant_busy), .ant_wr_x(s_ant_x), .ant_wr_y(s_ant_y),
    .rd_x(s_rd_x), .rd_y(s_rd_y), .rd_signal(s_rd_signal),
    .wr_x(s_wr_x), .wr_y(s_wr_y), .wr_signal(s_wr_signal), .wr_en(s_wr_en),
    .busy(s_busy), .sweep_done(s_done), .overrun(s_overrun)
  );

  // environment memories
  logic [3:0] mem      [160][120];
  logic [3:0] init_mem [160][120];
  int         exp_mem  [160][120];
  logic       load_req;
  logic [3:0] smem     [8][4];
  int         s_pre    [8][4];
  logic       s_load;

  int write_count, port_conflicts, s_write_count, s_bad_writes;

  function automatic int decay(input int v, input int step);
    return (v > step) ? v - step : 0;
  endfunction

  always @(posedge clk) begin
    if (load_req) begin
      for (int x = 0; x < 160; x++)
        for (int y = 0; y < 120; y++)
          mem[x][y] <= init_mem[x][y];
      rd_signal <= 4'd0;
    end else begin
      rd_signal <= (rd_x <= 8'd159 && rd_y <= 7'd119) ? mem[rd_x][rd_y] : 4'd0;
      if (ant_write_busy && ant_wr_x <= 8'd159 && ant_wr_y <= 7'd119)
        mem[ant_wr_x][ant_wr_y] <= ant_val;
      if (wr_en && wr_x <= 8'd159 && wr_y <= 7'd119)
        mem[wr_x][wr_y] <= wr_signal;
    end
  end

  always @(posedge clk) begin
    if (s_load) begin
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 4; y++)
          smem[x][y] <= 4'(s_pre[x][y]);
      s_rd_signal <= 4'd0;
    end else begin
      s_rd_signal <= smem[s_rd_x][s_rd_y];
      if (s_wr_en) smem[s_wr_x][s_wr_y] <= s_wr_signal;
    end
  end

  always @(negedge clk) begin
    if (wr_en) write_count++;
    if (wr_en && ant_write_busy) port_conflicts++;
    if (s_wr_en) begin
      s_write_count++;
      if (int'(s_wr_signal) != decay(s_pre[s_wr_x][s_wr_y], 3)) s_bad_writes++;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed != expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit tick, input bit abusy, input int ax, input int ay,
                               input int av);
    game_tick      = tick;
    ant_write_busy = abusy;
    ant_wr_x       = 8'(ax);
    ant_wr_y       = 7'(ay);
    ant_val        = 4'(av);
  endtask

  int done_at, s_done_at, stall_bad, exp_writes, s_exp_writes, mism, pre;
  bit prev_busy;

  initial begin
    check_count = 0; error_count = 0;
    write_count = 0; port_conflicts = 0; s_write_count = 0; s_bad_writes = 0;
    run = 1'b1; reset_sim = 1'b1; load_req = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    s_reset = 1'b1; s_run = 1'b1; s_tick = 1'b0; s_ant_busy = 1'b0;
    s_ant_x = 3'd0; s_ant_y = 2'd0; s_load = 1'b0;

    // random sparse field plus the hand-placed cells of interest
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        init_mem[x][y] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    init_mem[3][2]     = 4'd5;
    init_mem[159][119] = 4'd1;
    init_mem[7][0]     = 4'd9;
    init_mem[20][4]    = 4'($urandom_range(1, 15));
    // (50,50) is overwritten by the ant with 12 long before the sweep reaches it;
    // (20,4) is hit by the ant mid-cell, so it keeps the ant's 13 and is never written
    exp_writes = 0;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++) begin
        pre = (x == 50 && y == 50) ? 12 : int'(init_mem[x][y]);
        exp_mem[x][y] = decay(pre, 1);
        if (pre != 0 && !(x == 20 && y == 4)) exp_writes++;
      end
    exp_mem[20][4] = 13;

    load_req = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_sim = 1'b0; s_reset = 1'b0; load_req = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wr_en", wr_en, 0);
    checkOutput("reset_sweep_done", sweep_done, 0);
    checkOutput("reset_overrun", overrun, 0);
    checkOutput("reset_rd_addr", {rd_x, rd_y}, 0);
    checkOutput("reset_wr_bus", {wr_x, wr_y, wr_signal}, 0);
    @(posedge clk); #1;

    // ---------------- sweep 1: full grid, stall at (7,0), collision at (20,4)
    write_count = 0; port_conflicts = 0;
    applyStimulus(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    done_at = -1; stall_bad = 0; prev_busy = 1'b0;
    for (int n = 0; n < 60000 && done_at < 0; n++) begin
      if (n >= 23 && n <= 32)  applyStimulus(0, 1, 50, 50, 12);
      else if (n == 1991)      applyStimulus(0, 1, 20, 4, 13);
      else                     applyStimulus(0, 0, 0, 0, 0);
      @(negedge clk);
      if (n == 0) begin
        checkOutput("tick_busy", busy, 1);
        checkOutput("first_rd_x", rd_x, 0);
        checkOutput("first_rd_y", rd_y, 0);
      end
      if (n >= 23 && n <= 32 && wr_en) stall_bad++;
      if (n == 33) begin
        checkOutput("stall_release_wr_en", wr_en, 1);
        checkOutput("stall_release_wr_x", wr_x, 7);
        checkOutput("stall_release_wr_y", wr_y, 0);
        checkOutput("stall_release_value", wr_signal, 8);
      end
      if (n == 1992) checkOutput("collision_no_write", wr_en, 0);
      if (sweep_done) begin
        done_at = n;
        checkOutput("busy_at_done", busy, 0);
        checkOutput("busy_before_done", prev_busy, 1);
      end
      prev_busy = busy;
      @(posedge clk); #1;
    end
    checkOutput("stall_wr_en_low", stall_bad, 0);
    checkOutput("done_cycle", (done_at >= 57608 && done_at <= 57612) ? 57610 : done_at, 57610);
    @(negedge clk);
    checkOutput("done_one_cycle", sweep_done, 0);
    checkOutput("idle_busy", busy, 0);
    mism = 0;
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        if (int'(mem[x][y]) != exp_mem[x][y]) mism++;
    checkOutput("mem_mismatches", mism, 0);
    checkOutput("cell_3_2", mem[3][2], 4);
    checkOutput("cell_159_119", mem[159][119], 0);
    checkOutput("cell_20_4_ant_value", mem[20][4], 13);
    checkOutput("cell_50_50", mem[50][50], 11);
    checkOutput("write_count", write_count, exp_writes);
    checkOutput("port_conflicts", port_conflicts, 0);
    checkOutput("overrun_after_clean_sweep", overrun, 0);
    @(posedge clk); #1;

    // ---------------- sweep 2: extra tick at 1000, RUN dropped at 1500
    applyStimulus(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int n = 0; n < 1503; n++) begin
      applyStimulus(n == 1000, 0, 0, 0, 0);
      run = (n != 1500);
      @(negedge clk);
      if (n == 999) checkOutput("overrun_before_tick", overrun, 0);
      if (n == 1001) begin
        checkOutput("overrun_set", overrun, 1);
        checkOutput("busy_after_extra_tick", busy, 1);
      end
      if (n == 1003) checkOutput("no_restart_addr", {rd_x, rd_y}, {8'd14, 7'd2});
      if (n == 1501) begin
        checkOutput("run_low_busy", busy, 0);
        checkOutput("run_low_wr_en", wr_en, 0);
        checkOutput("run_low_overrun_held", overrun, 1);
      end
      @(posedge clk); #1;
    end
    run = 1'b1;
    game_tick = 1'b0;

    // ---------------- sweep 3: reset at 2000
    applyStimulus(1, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int n = 0; n < 2003; n++) begin
      applyStimulus(0, 0, 0, 0, 0);
      reset_sim = (n == 2000);
      @(negedge clk);
      if (n == 1999) checkOutput("pre_reset_busy", busy, 1);
      if (n == 2001) begin
        checkOutput("post_reset_busy", busy, 0);
        checkOutput("post_reset_wr_en", wr_en, 0);
        checkOutput("post_reset_overrun", overrun, 0);
        checkOutput("post_reset_rd_addr", {rd_x, rd_y}, 0);
      end
      @(posedge clk); #1;
    end
    reset_sim = 1'b0;

    // ---------------- small grid, decay step 3
    for (int rep = 0; rep < 2; rep++) begin
      s_exp_writes = 0;
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 4; y++)
          s_pre[x][y] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                                    : int'($urandom_range(4, 15));
      s_pre[2][1] = 2;
      s_pre[5][3] = 0;
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 4; y++)
          if (s_pre[x][y] != 0) s_exp_writes++;
      s_load = 1'b1;
      @(posedge clk); #1;
      s_load = 1'b0;
      s_write_count = 0; s_bad_writes = 0;
      s_tick = 1'b1;
      @(posedge clk); #1;
      s_done_at = -1;
      for (int n = 0; n < 100; n++) begin
        s_tick = (rep == 0 && n == 96);
        @(negedge clk);
        if (s_done && s_done_at < 0) s_done_at = n;
        if (rep == 0 && n == 95) checkOutput("s_overrun_before", s_overrun, 0);
        if (rep == 0 && n == 97) begin
          checkOutput("s_tick_in_done_busy", s_busy, 0);
          checkOutput("s_tick_in_done_overrun", s_overrun, 1);
        end
        if (rep == 0 && n == 98) checkOutput("s_no_restart", s_busy, 0);
        @(posedge clk); #1;
      end
      s_tick = 1'b0;
      checkOutput("s_done_cycle", (s_done_at >= 94 && s_done_at <= 98) ? 96 : s_done_at, 96);
      mism = 0;
      for (int x = 0; x < 8; x++)
        for (int y = 0; y < 4; y++)
          if (int'(smem[x][y]) != decay(s_pre[x][y], 3)) mism++;
      checkOutput("s_mem_mismatches", mism, 0);
      checkOutput("s_saturated_cell", smem[2][1], 0);
      checkOutput("s_zero_cell", smem[5][3], 0);
      checkOutput("s_write_count", s_write_count, s_exp_writes);
      checkOutput("s_bad_write_values", s_bad_writes, 0);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
